// File: rtl/intr_ack_initiator.sv
// Purpose: CPU-side 8259 INT/INTA initiator; runs the two-pulse acknowledge and captures the vector (INTA_SYNC_EN adds a 2-flop int_in synchronizer).
// Latency: vector_valid rises 2L+G+1 edges after int_in is driven high (+2 with INTA_SYNC_EN).
// Backpressure: vector held in DELIVER until vector_ready; no new acknowledge starts meanwhile.
module intr_ack_initiator #(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_in,
    input  logic       cpu_ie,
    input  logic [7:0] data_bus,
    output logic       inta_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       busy
);

    localparam int MAXLG = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int CW    = $clog2(MAXLG) + 1;
    localparam logic [CW-1:0] LOW_LD = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(INTA_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_LOW  = 3'd1,
        GAP     = 3'd2,
        P2_LOW  = 3'd3,
        DELIVER = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          cap;
    logic          int_s;

`ifdef INTA_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], int_in};
        end
    end

    assign int_s = sync_q[1];
`else
    assign int_s = int_in;
`endif

    // Once out of IDLE the sequence ignores int_s/cpu_ie so the PIC always sees both pulses.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (int_s && cpu_ie) begin
                    state_nxt = P1_LOW;
                    cnt_nxt   = LOW_LD;
                end
            end
            P1_LOW: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = P2_LOW;
                    cnt_nxt   = LOW_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            P2_LOW: begin
                if (cnt == '0) begin
                    state_nxt = DELIVER;
                    cnt_nxt   = '0;
                    cap       = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DELIVER: begin
                if (vector_ready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            inta_n       <= 1'b1;
            vector_valid <= 1'b0;
            vector       <= 8'h00;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            inta_n       <= !((state_nxt == P1_LOW) || (state_nxt == P2_LOW));
            vector_valid <= (state_nxt == DELIVER);
            if (cap) begin
                vector <= data_bus;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_intr_ack_initiator.sv
// Directed bench for intr_ack_initiator at default L=2, G=2; edge numbers shift by S under INTA_SYNC_EN.
module tb_intr_ack_initiator;

`ifdef INTA_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       int_in;
    logic       cpu_ie;
    logic [7:0] data_bus;
    logic       inta_n;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ready;
    logic       busy;

    int errors;
    int checks;

    intr_ack_initiator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_in       (int_in),
        .cpu_ie       (cpu_ie),
        .data_bus     (data_bus),
        .inta_n       (inta_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int_in       = 1'b0;
        cpu_ie       = 1'b0;
        vector_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        int_in       = 1'b0;
        cpu_ie       = 1'b0;
        data_bus     = 8'h00;
        vector_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (inta_n !== 1'b1) begin errors++; $display("FAIL reset_inta got=%b exp=1", inta_n); end
        checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vector_valid); end
        checks++; if (vector !== 8'h00) begin errors++; $display("FAIL reset_vector got=%h exp=00", vector); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        logic exp_inta, exp_vld, exp_busy;
        int_in       = 1'b1;
        cpu_ie       = 1'b1;
        vector_ready = 1'b1;
        data_bus     = 8'hC3;
        for (int k = 1; k <= 11 + S; k++) begin
            tick();
            if (k == 1) int_in = 1'b0;
            data_bus = (k == 6 + S) ? 8'h4A : ((k == 5 + S) ? 8'h12 : 8'hC3);
            exp_inta = !((k == 1 + S) || (k == 2 + S) || (k == 5 + S) || (k == 6 + S));
            exp_vld  = (k == 7 + S);
            exp_busy = (k >= 1 + S) && (k <= 7 + S);
            checks++; if (inta_n !== exp_inta) begin errors++; $display("FAIL basic_inta edge=%0d got=%b exp=%b", k, inta_n, exp_inta); end
            checks++; if (vector_valid !== exp_vld) begin errors++; $display("FAIL basic_valid edge=%0d got=%b exp=%b", k, vector_valid, exp_vld); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL basic_busy edge=%0d got=%b exp=%b", k, busy, exp_busy); end
            if (k == 7 + S) begin
                checks++; if (vector !== 8'h4A) begin errors++; $display("FAIL basic_vector got=%h exp=4a", vector); end
            end
        end
        checks++; if (vector !== 8'h4A) begin errors++; $display("FAIL basic_vector_hold got=%h exp=4a", vector); end
    endtask

    task automatic test_ie_gate();
        int_in       = 1'b1;
        cpu_ie       = 1'b0;
        vector_ready = 1'b1;
        data_bus     = 8'h33;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (inta_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ie_gate edge=%0d got inta_n=%b busy=%b exp inta_n=1 busy=0", k, inta_n, busy); end
        end
        cpu_ie = 1'b1;
        tick();
        int_in = 1'b0;
        checks++; if (inta_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ie_start got inta_n=%b busy=%b exp inta_n=0 busy=1", inta_n, busy); end
        settle();
    endtask

    task automatic test_backpressure();
        int_in       = 1'b1;
        cpu_ie       = 1'b1;
        vector_ready = 1'b0;
        data_bus     = 8'h5C;
        for (int k = 1; k <= 7 + S; k++) tick();
        data_bus = 8'hEE;
        checks++; if (vector_valid !== 1'b1 || vector !== 8'h5C) begin errors++; $display("FAIL bp_first got valid=%b vector=%h exp valid=1 vector=5c", vector_valid, vector); end
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (vector_valid !== 1'b1 || vector !== 8'h5C || inta_n !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got valid=%b vector=%h inta_n=%b exp valid=1 vector=5c inta_n=1", k, vector_valid, vector, inta_n); end
        end
        vector_ready = 1'b1;
        tick();
        checks++; if (vector_valid !== 1'b0 || busy !== 1'b0 || inta_n !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b busy=%b inta_n=%b exp valid=0 busy=0 inta_n=1", vector_valid, busy, inta_n); end
        tick();
        int_in = 1'b0;
        checks++; if (inta_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_restart got inta_n=%b busy=%b exp inta_n=0 busy=1", inta_n, busy); end
        settle();
    endtask

    task automatic test_drop_in_gap();
        int_in       = 1'b1;
        cpu_ie       = 1'b1;
        vector_ready = 1'b1;
        data_bus     = 8'h91;
        for (int k = 1; k <= 10 + S; k++) begin
            tick();
            if (k == 3 + S) begin
                int_in = 1'b0;
                cpu_ie = 1'b0;
            end
            if (k == 5 + S) begin
                checks++; if (inta_n !== 1'b0) begin errors++; $display("FAIL gap_p2 got inta_n=%b exp=0", inta_n); end
            end
            if (k == 7 + S) begin
                checks++; if (vector_valid !== 1'b1 || vector !== 8'h91) begin errors++; $display("FAIL gap_deliver got valid=%b vector=%h exp valid=1 vector=91", vector_valid, vector); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int_in       = 1'b1;
        cpu_ie       = 1'b1;
        vector_ready = 1'b1;
        data_bus     = 8'h77;
        for (int k = 1; k <= 5 + S; k++) begin
            tick();
            if (k == 1) int_in = 1'b0;
        end
        checks++; if (inta_n !== 1'b0) begin errors++; $display("FAIL rst_mid_pre got inta_n=%b exp=0", inta_n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (inta_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_async got inta_n=%b busy=%b exp inta_n=1 busy=0", inta_n, busy); end
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (vector !== 8'h00) begin errors++; $display("FAIL rst_mid_vector got=%h exp=00", vector); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (vector_valid !== 1'b0 || inta_n !== 1'b1) begin errors++; $display("FAIL rst_mid_after cyc=%0d got valid=%b inta_n=%b exp valid=0 inta_n=1", k, vector_valid, inta_n); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        settle();
        test_ie_gate();
        test_backpressure();
        test_drop_in_gap();
        settle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
